// File: rtl/apb_uart_param.sv
// APB3 UART with configurable FIFO depth, character width and oversampling.
// Zero-wait slave exposing SR/DR/BRR/CR, W1C sticky flags and a registered level IRQ.
module apb_uart_param #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [4:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        RXD,
    output logic        TXD,
    output logic        UART_IRQ
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    logic        access, wr, rd;
    logic [2:0]  idx;
    logic        sel_sr, sel_dr, sel_brr, sel_cr, sr_w1c, flush;
    logic        unused;

    logic [15:0] brr;
    logic [11:0] cr;
    logic        uen, txen, rxen, pen, podd, stop2;
    logic        tc, pe, fe, rxovr, txovr, irq_q;
    logic [15:0] div_cnt;
    logic        tick;

    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [AW:0]          tx_wp, tx_rp, tx_lvl;
    logic                 tx_empty, tx_full, tx_push_req, tx_push, tx_start, txovr_set;

    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0]          rx_wp, rx_rp, rx_lvl;
    logic                 rx_empty, rx_full, rx_pop, rx_push, rxovr_set;

    state_t               tx_state;
    logic [CW-1:0]        tx_cnt;
    logic [2:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par, tx_stop_n, txd_q, tx_done;

    state_t               rx_state;
    logic [CW-1:0]        rx_cnt;
    logic [2:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shift, rx_data_q;
    logic                 rx_par, rx_s1, rx_s2, rx_prev;
    logic                 rx_push_q, pe_set_q, fe_set_q;
    logic                 rx_sample, rx_last;

    logic [31:0]          sr_val;

    assign access  = PSEL & PENABLE;
    assign wr      = access & PWRITE;
    assign rd      = access & ~PWRITE;
    assign idx     = PADDR[4:2];
    assign sel_sr  = (idx == 3'd0);
    assign sel_dr  = (idx == 3'd1);
    assign sel_brr = (idx == 3'd2);
    assign sel_cr  = (idx == 3'd3);
    assign sr_w1c  = wr & sel_sr;
    assign unused  = ^{PADDR[1:0], PWDATA[31:16]};

    assign uen   = cr[0];
    assign txen  = cr[1];
    assign rxen  = cr[2];
    assign pen   = cr[3];
    assign podd  = cr[4];
    assign stop2 = cr[5];

    // A CR write that drops UEN flushes the FIFOs and aborts both engines in the same edge.
    assign flush = wr & sel_cr & uen & ~PWDATA[0];

    assign PREADY   = 1'b1;
    assign PSLVERR  = access & idx[2];
    assign TXD      = txd_q;
    assign UART_IRQ = irq_q;

    assign tick = uen & (div_cnt == brr);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)       div_cnt <= '0;
        else if (!uen || tick) div_cnt <= '0;
        else                div_cnt <= div_cnt + 16'd1;
    end

    // TX FIFO: a push into a full FIFO is still accepted when the engine pops in the same cycle.
    assign tx_lvl      = tx_wp - tx_rp;
    assign tx_empty    = (tx_lvl == '0);
    assign tx_full     = (tx_lvl == FULL_LVL);
    assign tx_push_req = wr & sel_dr;
    assign tx_start    = (tx_state == ST_IDLE) & uen & txen & ~tx_empty & ~flush;
    assign tx_push     = tx_push_req & (~tx_full | tx_start);
    assign txovr_set   = tx_push_req & tx_full & ~tx_start;

    always_ff @(posedge PCLK) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= PWDATA[DATA_BITS-1:0];
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_data_q;
    end

    assign rx_lvl    = rx_wp - rx_rp;
    assign rx_empty  = (rx_lvl == '0);
    assign rx_full   = (rx_lvl == FULL_LVL);
    assign rx_pop    = rd & sel_dr & ~rx_empty;
    assign rx_push   = rx_push_q & (~rx_full | rx_pop);
    assign rxovr_set = rx_push_q & rx_full & ~rx_pop;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else if (flush) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (tx_push)  tx_wp <= tx_wp + 1'b1;
            if (tx_start) tx_rp <= tx_rp + 1'b1;
            if (rx_push)  rx_wp <= rx_wp + 1'b1;
            if (rx_pop)   rx_rp <= rx_rp + 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_state  <= ST_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            tx_par    <= 1'b0;
            tx_stop_n <= 1'b0;
            txd_q     <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (flush) begin
                tx_state <= ST_IDLE;
                txd_q    <= 1'b1;
            end else if (tx_state == ST_IDLE) begin
                if (tx_start) begin
                    tx_state  <= ST_START;
                    txd_q     <= 1'b0;
                    tx_cnt    <= '0;
                    tx_stop_n <= 1'b0;
                    tx_shift  <= tx_mem[tx_rp[AW-1:0]];
                    tx_par    <= (^tx_mem[tx_rp[AW-1:0]]) ^ podd;
                end
            end else if (tick) begin
                if (tx_cnt != CNT_LAST) begin
                    tx_cnt <= tx_cnt + 1'b1;
                end else begin
                    tx_cnt <= '0;
                    case (tx_state)
                        ST_START: begin
                            tx_state <= ST_DATA;
                            tx_bit   <= '0;
                            txd_q    <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                        ST_DATA: begin
                            if (tx_bit == BIT_LAST) begin
                                tx_state <= pen ? ST_PARITY : ST_STOP;
                                txd_q    <= pen ? tx_par : 1'b1;
                            end else begin
                                tx_bit   <= tx_bit + 3'd1;
                                txd_q    <= tx_shift[0];
                                tx_shift <= tx_shift >> 1;
                            end
                        end
                        ST_PARITY: begin
                            tx_state <= ST_STOP;
                            txd_q    <= 1'b1;
                        end
                        ST_STOP: begin
                            if (stop2 && !tx_stop_n) begin
                                tx_stop_n <= 1'b1;
                            end else begin
                                tx_state <= ST_IDLE;
                                tx_done  <= 1'b1;
                            end
                        end
                        default: tx_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign rx_sample = (rx_cnt == CNT_HALF);
    assign rx_last   = (rx_cnt == CNT_LAST);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
            rx_state  <= ST_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_par    <= 1'b0;
            rx_data_q <= '0;
            rx_push_q <= 1'b0;
            pe_set_q  <= 1'b0;
            fe_set_q  <= 1'b0;
        end else begin
            rx_s1     <= RXD;
            rx_s2     <= rx_s1;
            rx_prev   <= rx_s2;
            rx_push_q <= 1'b0;
            pe_set_q  <= 1'b0;
            fe_set_q  <= 1'b0;
            if (flush) begin
                rx_state <= ST_IDLE;
            end else if (rx_state == ST_IDLE) begin
                if (uen && rxen && rx_prev && !rx_s2) begin
                    rx_state <= ST_START;
                    rx_cnt   <= '0;
                end
            end else if (tick) begin
                rx_cnt <= rx_last ? '0 : rx_cnt + 1'b1;
                case (rx_state)
                    ST_START: begin
                        if (rx_sample && rx_s2) begin
                            rx_state <= ST_IDLE;
                        end else if (rx_last) begin
                            rx_state <= ST_DATA;
                            rx_bit   <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (rx_sample) rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
                        if (rx_last) begin
                            if (rx_bit == BIT_LAST) rx_state <= pen ? ST_PARITY : ST_STOP;
                            else                    rx_bit   <= rx_bit + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        if (rx_sample) rx_par   <= rx_s2;
                        if (rx_last)   rx_state <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (rx_sample) begin
                            rx_state  <= ST_IDLE;
                            rx_push_q <= 1'b1;
                            rx_data_q <= rx_shift;
                            pe_set_q  <= pen & (rx_par != ((^rx_shift) ^ podd));
                            fe_set_q  <= ~rx_s2;
                        end
                    end
                    default: rx_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Sticky flags: a set event in the same cycle as the W1C write wins.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            brr   <= '0;
            cr    <= '0;
            tc    <= 1'b0;
            pe    <= 1'b0;
            fe    <= 1'b0;
            rxovr <= 1'b0;
            txovr <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (wr && sel_brr) brr <= PWDATA[15:0];
            if (wr && sel_cr)  cr  <= PWDATA[11:0] & 12'hF3F;
            tc    <= (tx_done & tx_empty) | (tc    & ~(sr_w1c & PWDATA[5]));
            pe    <= pe_set_q             | (pe    & ~(sr_w1c & PWDATA[6]));
            fe    <= fe_set_q             | (fe    & ~(sr_w1c & PWDATA[7]));
            rxovr <= rxovr_set            | (rxovr & ~(sr_w1c & PWDATA[8]));
            txovr <= txovr_set            | (txovr & ~(sr_w1c & PWDATA[9]));
            irq_q <= (cr[8] & ~rx_empty) | (cr[9] & tx_empty & uen & txen) |
                     (cr[10] & (pe | fe | rxovr | txovr)) | (cr[11] & tc);
        end
    end

    assign sr_val = {8'(tx_lvl), 8'(rx_lvl), 6'b0, txovr, rxovr, fe, pe, tc,
                     (tx_state != ST_IDLE), rx_full, tx_full, tx_empty, ~rx_empty};

    always_comb begin
        PRDATA = '0;
        if (rd) begin
            case (idx)
                3'd0:    PRDATA = sr_val;
                3'd1:    PRDATA = rx_empty ? '0 : 32'(rx_mem[rx_rp[AW-1:0]]);
                3'd2:    PRDATA = {16'b0, brr};
                3'd3:    PRDATA = {20'b0, cr};
                default: PRDATA = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_uart_param.sv
// Scoreboard bench for apb_uart_param: APB read and TXD frame monitors check queued
// expectations; directed sequences cover loopback, FIFO limits, RX errors and reset.
module tb_apb_uart_param;
    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [4:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR, TXD, UART_IRQ, RXD;
    logic        loop = 1'b0, rxd_drv = 1'b1, mon_en = 1'b0;

    int          n_checks = 0;
    int          n_pass = 0;
    string       rd_name_q[$];
    logic [32:0] rd_exp_q[$];
    logic [7:0]  frame_q[$];

    localparam logic [4:0] A_SR = 5'h00, A_DR = 5'h04, A_BRR = 5'h08, A_CR = 5'h0C;

    assign RXD = loop ? TXD : rxd_drv;

    always #5 PCLK = ~PCLK;

    apb_uart_param #(.FIFO_DEPTH(16), .DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .RXD(RXD), .TXD(TXD), .UART_IRQ(UART_IRQ)
    );

    function automatic void check(string name, logic [32:0] act, logic [32:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%09h expected 0x%09h", name, act, exp);
    endfunction

    // Read monitor: {PSLVERR, PRDATA} in the access phase against the queued expectation.
    always @(negedge PCLK) begin
        if (PRESETn && PSEL && PENABLE && !PWRITE) begin
            if (rd_exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_read: got 0x%08h with nothing expected", PRDATA);
            end else begin
                check(rd_name_q.pop_front(), {PSLVERR, PRDATA}, rd_exp_q.pop_front());
            end
        end
    end

    // Frame monitor: decodes 8N1 frames on TXD at BRR=0 (16 cycles per bit), mid-bit sampling.
    initial begin
        logic [7:0] d;
        logic       st, sp;
        forever begin
            @(negedge PCLK);
            if (mon_en && PRESETn && TXD === 1'b0) begin
                repeat (8) @(negedge PCLK);
                st = TXD;
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge PCLK);
                    d[i] = TXD;
                end
                repeat (16) @(negedge PCLK);
                sp = TXD;
                if (frame_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL tx_frame: got unexpected frame 0x%02h", d);
                end else begin
                    check("tx_frame", 33'({st, d, sp}), 33'({1'b0, frame_q.pop_front(), 1'b1}));
                end
            end
        end
    end

    task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [4:0] a, input logic [31:0] exp, input logic err,
                            input string name);
        rd_name_q.push_back(name);
        rd_exp_q.push_back({err, exp});
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic par_en, input logic par,
                           input logic stopb);
        @(posedge PCLK); #1 rxd_drv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(posedge PCLK); #1 rxd_drv = d[i];
        end
        if (par_en) begin
            repeat (16) @(posedge PCLK); #1 rxd_drv = par;
        end
        repeat (16) @(posedge PCLK); #1 rxd_drv = stopb;
        repeat (16) @(posedge PCLK); #1 rxd_drv = 1'b1;
        repeat (4) @(posedge PCLK);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge PCLK);
        check("reset_txd", 33'(TXD), 33'd1);
        check("reset_irq", 33'(UART_IRQ), 33'd0);
        check("reset_prdata", 33'(PRDATA), 33'd0);
        #1 PRESETn = 1'b1;

        // Register map
        apb_read(A_SR, 32'h0000_0002, 1'b0, "sr_reset");
        apb_write(A_CR, 32'hFFFF_FFFE);
        apb_read(A_CR, 32'h0000_0F3E, 1'b0, "cr_mask");
        apb_write(A_CR, 32'h0);
        apb_write(A_BRR, 32'hABCD_1234);
        apb_read(A_BRR, 32'h0000_1234, 1'b0, "brr_rw");
        apb_write(A_BRR, 32'h0);
        apb_write(5'h14, 32'hFFFF_FFFF);
        apb_read(5'h10, 32'h0, 1'b1, "undecoded_rd");
        apb_read(5'h1C, 32'h0, 1'b1, "undecoded_rd2");

        // Loopback single byte
        loop = 1'b1;
        mon_en = 1'b1;
        apb_write(A_CR, 32'h107);
        frame_q.push_back(8'hA5);
        apb_write(A_DR, 32'hA5);
        repeat (200) @(posedge PCLK);
        #1 check("irq_rxne", 33'(UART_IRQ), 33'd1);
        apb_read(A_SR, 32'h0001_0023, 1'b0, "sr_after_loop");
        apb_read(A_DR, 32'h0000_00A5, 1'b0, "dr_loop");
        apb_read(A_SR, 32'h0000_0022, 1'b0, "sr_after_pop");
        repeat (2) @(posedge PCLK);
        #1 check("irq_rxne_clr", 33'(UART_IRQ), 33'd0);

        // TX FIFO fill and overflow, then drain
        apb_write(A_CR, 32'h01);
        apb_write(A_SR, 32'h20);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) frame_q.push_back(8'(8'h10 + i));
            apb_write(A_DR, 32'(8'h10 + i));
        end
        apb_read(A_SR, 32'h1000_0204, 1'b0, "sr_tx_full");
        apb_write(A_SR, 32'h200);
        apb_read(A_SR, 32'h1000_0004, 1'b0, "sr_txovr_clr");
        apb_write(A_CR, 32'h03);
        repeat (2700) @(posedge PCLK);
        apb_read(A_SR, 32'h0000_0022, 1'b0, "sr_tx_done");
        check("frames_drained", 33'(frame_q.size()), 33'd0);

        // Parity error
        mon_en = 1'b0;
        loop = 1'b0;
        apb_write(A_SR, 32'h3E0);
        apb_write(A_CR, 32'h40D);
        send_rx(8'h03, 1'b1, 1'b1, 1'b1);
        check("irq_pe", 33'(UART_IRQ), 33'd1);
        apb_read(A_SR, 32'h0001_0043, 1'b0, "sr_pe");
        apb_read(A_DR, 32'h0000_0003, 1'b0, "dr_pe_byte");
        check("irq_pe_sticky", 33'(UART_IRQ), 33'd1);
        apb_write(A_SR, 32'h40);
        repeat (2) @(posedge PCLK);
        #1 check("irq_pe_clr", 33'(UART_IRQ), 33'd0);
        apb_read(A_SR, 32'h0000_0002, 1'b0, "sr_pe_clr");

        // Framing error, false start
        apb_write(A_CR, 32'h405);
        send_rx(8'h5A, 1'b0, 1'b0, 1'b0);
        apb_read(A_SR, 32'h0001_0083, 1'b0, "sr_fe");
        apb_read(A_DR, 32'h0000_005A, 1'b0, "dr_fe_byte");
        apb_write(A_SR, 32'h80);
        @(posedge PCLK); #1 rxd_drv = 1'b0;
        repeat (4) @(posedge PCLK); #1 rxd_drv = 1'b1;
        repeat (40) @(posedge PCLK);
        apb_read(A_SR, 32'h0000_0002, 1'b0, "sr_glitch");
        send_rx(8'h3C, 1'b0, 1'b0, 1'b1);
        apb_read(A_DR, 32'h0000_003C, 1'b0, "dr_after_glitch");

        // RX FIFO full: pop coincident with push, then overflow
        apb_write(A_CR, 32'h05);
        for (int i = 0; i < 16; i++) send_rx(8'(8'h40 + i), 1'b0, 1'b0, 1'b1);
        apb_read(A_SR, 32'h0010_000B, 1'b0, "sr_rx_full");
        @(posedge PCLK);
        fork
            send_rx(8'h77, 1'b0, 1'b0, 1'b1);
            begin
                repeat (155) @(posedge PCLK);
                apb_read(A_DR, 32'h0000_0040, 1'b0, "dr_simul_pop");
            end
        join
        apb_read(A_SR, 32'h0010_000B, 1'b0, "sr_simul");
        send_rx(8'h78, 1'b0, 1'b0, 1'b1);
        apb_read(A_SR, 32'h0010_010B, 1'b0, "sr_rxovr");
        for (int i = 1; i < 16; i++) apb_read(A_DR, 32'(8'h40 + i), 1'b0, "dr_drain");
        apb_read(A_DR, 32'h0000_0077, 1'b0, "dr_tail");
        apb_read(A_DR, 32'h0, 1'b0, "dr_empty");
        apb_read(A_SR, 32'h0000_0102, 1'b0, "sr_drained");

        // Reset in the middle of a TX frame
        loop = 1'b1;
        apb_write(A_CR, 32'h107);
        apb_write(A_DR, 32'hA5);
        repeat (72) @(posedge PCLK);
        #3 check("txd_bit3", 33'(TXD), 33'd0);
        PRESETn = 1'b0;
        #1 check("txd_async_reset", 33'(TXD), 33'd1);
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        apb_read(A_SR, 32'h0000_0002, 1'b0, "sr_post_reset");
        apb_read(A_CR, 32'h0, 1'b0, "cr_post_reset");
        repeat (200) @(posedge PCLK);
        apb_read(A_SR, 32'h0000_0002, 1'b0, "sr_no_rx_push");

        check("reads_consumed", 33'(rd_exp_q.size()), 33'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/apb_uart_param.md
Name: apb_uart_param

Overview:
- Parametrised APB3 UART peripheral, successor to the fixed 8-bit APB UART.
- Self-contained block with:
  - zero-wait APB slave;
  - configurable-depth TX and RX FIFOs;
  - 16-bit fractional-free baud divisor;
  - configurable data width, optional parity, 1 or 2 stop bits;
  - sticky error flags and a masked level interrupt.
- Sits on the Cortex-M0 APB bus beside the other APB peripherals.

Parameters:
- FIFO_DEPTH, 16: entries per FIFO; power of 2, range 2..128.
- DATA_BITS, 8: character width, range 5..8.
- OVERSAMPLE, 16: baud ticks per bit; even, range 8..16.

Ports:
- PCLK  in  1  APB clock; the only clock.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  5  byte address; only [4:2] decoded.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data; combinational, valid in access phase.
- PREADY  out  1  tied 1.
- PSLVERR  out  1  1 for an access to an undecoded offset, else 0.
- RXD  in  1  serial in; asynchronous.
- TXD  out  1  serial out; idle high.
- UART_IRQ  out  1  level interrupt, active high.

Behaviour:
- Reset (PRESETn low, asynchronous):
  - all registers 0, FIFOs empty, engines IDLE;
  - TXD=1, UART_IRQ=0, PRDATA=0 when not reading.
- APB access:
  - An access completes on PSEL&PENABLE; write takes effect at that edge.
  - Offsets: 0x00 SR, 0x04 DR, 0x08 BRR, 0x0C CR.
  - Other offsets: read 0, write ignored, PSLVERR=1.
- DR:
  - Write pushes PWDATA[DATA_BITS-1:0] into the TX FIFO.
  - If the TX FIFO is full, the data is dropped and SR.TXOVR is set.
  - Read returns the RX FIFO head, zero-extended, and pops it.
  - If the RX FIFO is empty, read returns 0 with no pop.
- BRR[15:0] DIV: baud tick every DIV+1 PCLK cycles; bit period = OVERSAMPLE ticks.
- CR:
  - [0] UEN
  - [1] TXEN
  - [2] RXEN
  - [3] PEN
  - [4] PODD (0 = even)
  - [5] STOP2
  - [8] IE_RXNE
  - [9] IE_TXE
  - [10] IE_ERR
  - [11] IE_TC
  - UEN 1->0 flushes both FIFOs, aborts both engines to IDLE and forces TXD=1. BRR and CR are retained.
- SR bits [4:0], read-only levels:
  - RXNE = RX FIFO not empty
  - TXE = TX FIFO empty
  - TXFULL
  - RXFULL
  - BUSY = TX engine not IDLE
- SR bits [9:5], sticky; writing 1 clears, writing 0 has no effect:
  - TC = TX went IDLE with TX FIFO empty
  - PE = parity error
  - FE = framing error
  - RXOVR = RX FIFO overflow
  - TXOVR = TX FIFO overflow
- SR level fields:
  - [23:16] RX FIFO level
  - [31:24] TX FIFO level
- Set vs clear: a set event in the same cycle as a W1C write wins.
- FIFOs:
  - Circular buffers with an extra pointer bit; level ranges 0..FIFO_DEPTH.
  - Simultaneous push and pop when full: the pop frees the slot and the push is accepted, level unchanged, no overflow.
  - Simultaneous push and pop when empty: the push is accepted, the pop returns 0, level becomes 1.
- TX engine:
  - States: IDLE -> START -> DATA -> PARITY (only if PEN) -> STOP (1 or 2 bits) -> IDLE.
  - Leaves IDLE when UEN&TXEN and the FIFO is not empty; pops the FIFO on that transition.
  - Data is sent LSB first. Parity = XOR of the data bits, inverted when PODD.
  - Clearing TXEN mid-frame finishes the current frame.
- RX engine:
  - RXD passes through a 2-flop synchroniser.
  - States: IDLE -> START -> DATA -> PARITY (only if PEN) -> STOP -> IDLE.
  - A falling edge in IDLE with UEN&RXEN enters START.
  - Sampling is at tick OVERSAMPLE/2 of each bit. If the start sample is high, it is a false start and the engine returns to IDLE.
  - The stop sample is taken on the first stop bit only.
  - In STOP: push the byte to the RX FIFO, set PE on parity mismatch, set FE if the stop sample is 0. The byte is pushed even on error.
  - If the RX FIFO is full, the byte is dropped and RXOVR is set.
- Interrupt, registered (asserts 1 cycle after the cause):
  - UART_IRQ = (IE_RXNE & RXNE) | (IE_TXE & TXE & UEN & TXEN) | (IE_ERR & (PE|FE|RXOVR|TXOVR)) | (IE_TC & TC).
- Reset mid-frame: TXD returns to 1 asynchronously. No partial byte is pushed.

Test Plan:
- Loopback (RXD=TXD), BRR=0, OVERSAMPLE=16, CR=0x107, write DR=0xA5 -> TXD low 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, high for the stop bit; after the frame SR.RXNE=1, UART_IRQ=1, read DR=0x000000A5, then SR.RXNE=0 and UART_IRQ=0.
- CR=0x01 (TXEN=0), write DR 17 times -> SR[31:24]=16, TXFULL=1, TXOVR=1; W1C SR=0x200 -> TXOVR=0; then set TXEN -> 16 frames sent, after which TC=1 and BUSY=0.
- PEN=1, PODD=0, inject a frame of 0x03 with parity bit 1 on RXD -> SR.PE=1, DR reads 0x03; with IE_ERR=1, UART_IRQ=1 until PE is cleared.
- Inject a frame with stop bit 0 -> FE=1, byte pushed. Inject a 0.25-bit low glitch -> no push, engine back in IDLE.
- Fill the RX FIFO to 16, then perform a DR read in the same cycle as an incoming byte push -> level stays 16, RXOVR=0. Without a read, the next byte sets RXOVR=1 and the level stays 16.
- Assert PRESETn low mid-TX-frame at data bit 3 -> TXD=1 immediately, SR=0x00000002 after release, no spurious RX push.
